// File: rtl/serial_tx_buffer_pkg.sv
// Shared types and constants for the serial transmit buffer: launch FSM state
// encoding and the byte width used by the FIFO and the transmitter interface.
package serial_tx_buffer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_ACK  = 2'b01,
        ST_WAIT_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_txbuf_fifo.sv
// Byte FIFO for the serial transmit buffer: DEPTH x BYTE_W array, wrapping
// read/write pointers and an occupancy count. Push/pop qualification is done by the caller.
module serial_txbuf_fifo
    import serial_tx_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [BYTE_W-1:0] wr_data_i,
    input  logic              pop_i,
    output logic [BYTE_W-1:0] rd_data_o,
    output logic [ADDR_W:0]   level_o
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the array is deliberately not reset; stale entries are never read
    // because count gates every pop, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = count_q;

endmodule

// File: rtl/serial_tx_buffer.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter's new_data/data/busy
// interface. Define SERIAL_TXBUF_CTS_EN to add the cts_n flow-control input.
module serial_tx_buffer
    import serial_tx_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_new_data,
    input  logic              tx_busy,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full
`ifdef SERIAL_TXBUF_CTS_EN
    ,
    input  logic              cts_n
`endif
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_new_data_q, tx_new_data_d;
    logic [BYTE_W-1:0] rd_data;
    logic [ADDR_W:0]   count;
    logic              push;
    logic              launch;
    logic              cts_clear;

    serial_txbuf_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .wr_data_i (in_data),
        .pop_i     (launch),
        .rd_data_o (rd_data),
        .level_o   (count)
    );

    // Status comes only from the count register, so in_valid never reaches in_ready.
    assign level    = count;
    assign empty    = (count == '0);
    assign full     = (count == FULL_LEVEL);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

`ifdef SERIAL_TXBUF_CTS_EN
    logic [1:0] cts_sync_q;

    always_ff @(posedge clk) begin
        if (rst) cts_sync_q <= 2'b11;
        else     cts_sync_q <= {cts_sync_q[0], cts_n};
    end

    assign cts_clear = !cts_sync_q[1];
`else
    assign cts_clear = 1'b1;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && !tx_busy && cts_clear) begin
                    launch  = 1'b1;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (tx_busy) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tx_data_d     = launch ? rd_data : tx_data_q;
    assign tx_new_data_d = launch;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tx_data_q     <= '0;
            tx_new_data_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_new_data_q <= tx_new_data_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_new_data = tx_new_data_q;

endmodule
